// File: rtl/mem_access_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the memory access arbiter:
//   state_e     : IDLE -> ISSUE -> WAIT -> RESP access sequence
//   src_e       : which requester owns the current access
//   DEF_*       : default widths and per-level latencies
//   access_lat  : latency of one access given its direction and hit flags
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        SRC_I,
        SRC_D
    } src_e;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_L1_LAT     = 1;
    localparam int unsigned DEF_L2_LAT     = 4;
    localparam int unsigned DEF_MM_LAT     = 12;

    // Writes always go all the way to main memory; reads stop at the
    // first level that hits.
    function automatic int unsigned access_lat(
        input logic        we,
        input logic        l1_hit,
        input logic        l2_hit,
        input int unsigned l1_lat,
        input int unsigned l2_lat,
        input int unsigned mm_lat
    );
        if (we)
            return mm_lat;
        else if (l1_hit)
            return l1_lat;
        else if (l2_hit)
            return l2_lat;
        return mm_lat;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter_if
// Bundles the fetch requester, data requester, cache-hierarchy port and the
// statistics outputs of mem_access_arbiter.
//   slave  : arbiter side (drives readys, responses, mem_* strobes, stats)
//   master : environment side (drives requests and hierarchy responses)
// ---------------------------------------------------------------------------
interface mem_access_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) ();

    // Fetch requester
    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_resp_valid;
    logic [DATA_WIDTH-1:0] i_resp_data;

    // Data requester
    logic                  d_req_valid;
    logic                  d_req_ready;
    logic                  d_req_we;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic [DATA_WIDTH-1:0] d_req_wdata;
    logic                  d_resp_valid;
    logic [DATA_WIDTH-1:0] d_resp_data;

    // Cache hierarchy port
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_l1_hit;
    logic                  mem_l2_hit;

    // Per-level access counters
    logic [31:0]           stat_l1;
    logic [31:0]           stat_l2;
    logic [31:0]           stat_mm;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_l1_hit, mem_l2_hit,
        output stat_l1, stat_l2, stat_mm
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_l1_hit, mem_l2_hit,
        input  stat_l1, stat_l2, stat_mm
    );

endinterface

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter (fetch vs data). On contention the side that
// was not granted last wins; a lone request always wins. The last-grant
// register moves only when the winner is actually accepted.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   i_valid_i    fetch requester valid
//   d_valid_i    data requester valid
//   accept_i     winner accepted this cycle
//   grant_o      current winner (meaningful when either valid is high)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_valid_i,
    input  logic d_valid_i,
    input  logic accept_i,
    output src_e grant_o
);

    src_e last_q;
    src_e last_d;

    always_comb begin
        grant_o = SRC_I;
        if (i_valid_i && d_valid_i)
            grant_o = (last_q == SRC_I) ? SRC_D : SRC_I;
        else if (d_valid_i)
            grant_o = SRC_D;

        last_d = last_q;
        if (accept_i)
            last_d = grant_o;
    end

    // Starting with "fetch granted last" lets data win the first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_q <= SRC_I;
        else
            last_q <= last_d;
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter
// Shares one cache-hierarchy access port between the instruction-fetch and
// data requesters. One access is in flight at a time; the response pulse is
// delayed by the latency of the level that hit (L1, L2 or main memory).
// Accept at cycle N gives the response pulse at cycle N+1+LAT.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous reset, active-low
//   bus   mem_access_arbiter_if.slave: request/response handshakes of both
//         requesters, mem_* hierarchy port, stat_l1/stat_l2/stat_mm counters
// Configuration macro:
//   MEM_ARB_STATS_EN  builds the per-level access counters; without it the
//                     stat_* outputs are tied to 0.
// ---------------------------------------------------------------------------
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned L1_LAT     = DEF_L1_LAT,
    parameter int unsigned L2_LAT     = DEF_L2_LAT,
    parameter int unsigned MM_LAT     = DEF_MM_LAT
) (
    input logic                 clk,
    input logic                 rst,
    mem_access_arbiter_if.slave bus
);

    localparam int CW = $clog2(MM_LAT + 1);

    state_e                state_q;
    state_e                state_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    src_e                  src_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] i_data_q;
    logic [DATA_WIDTH-1:0] d_data_q;

    src_e                  grant;
    logic                  accept;
    logic                  load_resp;
    logic [DATA_WIDTH-1:0] resp_word;
    logic [CW-1:0]         issue_cnt;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_valid_i (bus.i_req_valid),
        .d_valid_i (bus.d_req_valid),
        .accept_i  (accept),
        .grant_o   (grant)
    );

    // Ready is gated with rst so nothing is granted while reset is held.
    assign bus.i_req_ready = rst && (state_q == IDLE) && bus.i_req_valid && (grant == SRC_I);
    assign bus.d_req_ready = rst && (state_q == IDLE) && bus.d_req_valid && (grant == SRC_D);
    assign accept          = bus.i_req_ready || bus.d_req_ready;

    assign issue_cnt = CW'(access_lat(we_q, bus.mem_l1_hit, bus.mem_l2_hit,
                                      L1_LAT, L2_LAT, MM_LAT) - 1);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = issue_cnt;
                state_d = (issue_cnt == '0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response data is loaded on the edge into RESP so it is valid alongside
    // the pulse. An L1 hit goes ISSUE->RESP directly, before rdata_q exists.
    assign load_resp = (state_d == RESP) && (state_q != RESP) && !we_q;
    assign resp_word = (state_q == ISSUE) ? bus.mem_rdata : rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            src_q    <= SRC_I;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                src_q <= grant;
                if (grant == SRC_D) begin
                    we_q    <= bus.d_req_we;
                    addr_q  <= bus.d_req_addr;
                    wdata_q <= bus.d_req_wdata;
                end else begin
                    we_q    <= 1'b0;
                    addr_q  <= bus.i_req_addr;
                    wdata_q <= '0;
                end
            end
            if (state_q == ISSUE)
                rdata_q <= bus.mem_rdata;
            if (load_resp) begin
                if (src_q == SRC_D)
                    d_data_q <= resp_word;
                else
                    i_data_q <= resp_word;
            end
        end
    end

    assign bus.mem_en       = (state_q == ISSUE);
    assign bus.mem_we       = (state_q == ISSUE) && we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.i_resp_valid = (state_q == RESP) && (src_q == SRC_I);
    assign bus.d_resp_valid = (state_q == RESP) && (src_q == SRC_D);
    assign bus.i_resp_data  = i_data_q;
    assign bus.d_resp_data  = d_data_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_l1_q;
    logic [31:0] stat_l2_q;
    logic [31:0] stat_mm_q;

    // Exactly one counter moves per access, classified in the ISSUE cycle;
    // the counters wrap silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_l1_q <= '0;
            stat_l2_q <= '0;
            stat_mm_q <= '0;
        end else if (state_q == ISSUE) begin
            if (we_q)
                stat_mm_q <= stat_mm_q + 32'd1;
            else if (bus.mem_l1_hit)
                stat_l1_q <= stat_l1_q + 32'd1;
            else if (bus.mem_l2_hit)
                stat_l2_q <= stat_l2_q + 32'd1;
            else
                stat_mm_q <= stat_mm_q + 32'd1;
        end
    end

    assign bus.stat_l1 = stat_l1_q;
    assign bus.stat_l2 = stat_l2_q;
    assign bus.stat_mm = stat_mm_q;
`else
    assign bus.stat_l1 = '0;
    assign bus.stat_l2 = '0;
    assign bus.stat_mm = '0;
`endif

endmodule
